// File: rtl/l1ca_code_nco_pkg.sv
// Shared types for the L1 C/A code-rate NCO and its E/P/L delay line.
package l1ca_code_nco_pkg;

  localparam int NCO_W_DEF = 32;
  localparam int SLEW_W    = 11;

  typedef logic [NCO_W_DEF-1:0]       nco_word_t;
  typedef logic signed [SLEW_W-1:0]   code_slew_t;

  typedef enum logic [1:0] {
    SLEW_IDLE = 2'd0,
    SLEW_ADV  = 2'd1,
    SLEW_RET  = 2'd2
  } code_slew_state_t;

  typedef struct packed {
    logic early;
    logic prompt;
    logic late;
  } epl_t;

  // Magnitude of a signed slew; -1024 maps to 1024, which still fits 11 unsigned bits.
  function automatic logic [SLEW_W-1:0] slew_mag(input code_slew_t amt);
    return amt[SLEW_W-1] ? $unsigned(-amt) : $unsigned(amt);
  endfunction

endpackage

// File: rtl/l1ca_code_nco_nco.sv
// Half-chip phase accumulator: fcw register plus wrap-around accumulator with carry out.
module half_chip_nco #(
  parameter int NCO_W = 32
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic             clear,
  input  logic [NCO_W-1:0] fcw,
  input  logic             fcw_valid,
  output logic             carry
);

  logic [NCO_W-1:0] acc_q, acc_d;
  logic [NCO_W-1:0] fcw_q, fcw_d;
  logic [NCO_W:0]   sum;

  // clear resets phase only; the commanded rate survives a resync.
  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, fcw_q};
    carry = en & sum[NCO_W];
    acc_d = acc_q;
    fcw_d = fcw_q;
    if (clear) begin
      acc_d = '0;
    end else begin
      if (fcw_valid) fcw_d = fcw;
      if (en)        acc_d = sum[NCO_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      acc_q <= '0;
      fcw_q <= '0;
    end else begin
      acc_q <= acc_d;
      fcw_q <= fcw_d;
    end
  end

endmodule

// File: rtl/l1ca_code_nco.sv
// Code-rate NCO driving the C/A generator, with half-chip slew control and E/P/L delay line.
module l1ca_code_nco
  import l1ca_code_nco_pkg::*;
#(
  parameter int NCO_W = 32
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic             clear,
  input  logic [NCO_W-1:0] fcw,
  input  logic             fcw_valid,
  input  logic             slew_valid,
  output logic             slew_ready,
  input  code_slew_t       slew_amt,
  input  logic             code_in,
  input  logic             epoch_in,
  output logic             chip_en,
  output logic             code_clear,
  output logic             early,
  output logic             prompt,
  output logic             late,
  output logic             prompt_epoch
);

  logic             nat_evt, evt;
  code_slew_state_t state_q, state_d;
  logic [10:0]      rem_q, rem_d;
  logic             h_q, h_d;
  logic             chip_en_q, chip_en_d;
  logic             code_clear_q, code_clear_d;
  logic             evt_p1_q, evt_p1_d;
  logic             evt_p2_q, evt_p2_d;
  logic [2:0]       sr_q, sr_d;
  logic [2:0]       esr_q, esr_d;
  epl_t             epl;

  half_chip_nco #(.NCO_W(NCO_W)) u_nco (
    .clk       (clk),
    .nrst      (nrst),
    .en        (en),
    .clear     (clear),
    .fcw       (fcw),
    .fcw_valid (fcw_valid),
    .carry     (nat_evt)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    evt     = nat_evt;
    case (state_q)
      SLEW_IDLE: if (slew_valid && slew_amt != '0) begin
        state_d = slew_amt[10] ? SLEW_RET : SLEW_ADV;
        rem_d   = slew_mag(slew_amt);
      end
      // Injections fill cycles without a natural carry so events never collide.
      SLEW_ADV: if (en && !nat_evt) begin
        evt   = 1'b1;
        rem_d = rem_q - 11'd1;
        if (rem_q == 11'd1) state_d = SLEW_IDLE;
      end
      SLEW_RET: if (nat_evt) begin
        evt   = 1'b0;
        rem_d = rem_q - 11'd1;
        if (rem_q == 11'd1) state_d = SLEW_IDLE;
      end
      default: state_d = SLEW_IDLE;
    endcase

    h_d          = h_q ^ evt;
    chip_en_d    = evt & h_q;
    code_clear_d = clear;

    // p1: generator sees chip_en; p2: its new code is stable and gets sampled.
    evt_p1_d = evt;
    evt_p2_d = evt_p1_q;
    sr_d     = evt_p2_q ? {sr_q[1:0], code_in}   : sr_q;
    esr_d    = evt_p2_q ? {esr_q[1:0], epoch_in} : esr_q;

    if (clear) begin
      state_d   = SLEW_IDLE;
      rem_d     = '0;
      h_d       = 1'b0;
      chip_en_d = 1'b0;
      evt_p1_d  = 1'b0;
      evt_p2_d  = 1'b0;
      sr_d      = '0;
      esr_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= SLEW_IDLE;
      rem_q        <= '0;
      h_q          <= 1'b0;
      chip_en_q    <= 1'b0;
      code_clear_q <= 1'b0;
      evt_p1_q     <= 1'b0;
      evt_p2_q     <= 1'b0;
      sr_q         <= '0;
      esr_q        <= '0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      h_q          <= h_d;
      chip_en_q    <= chip_en_d;
      code_clear_q <= code_clear_d;
      evt_p1_q     <= evt_p1_d;
      evt_p2_q     <= evt_p2_d;
      sr_q         <= sr_d;
      esr_q        <= esr_d;
    end
  end

  assign epl          = '{early: sr_q[0], prompt: sr_q[1], late: sr_q[2]};
  assign early        = epl.early;
  assign prompt       = epl.prompt;
  assign late         = epl.late;
  assign prompt_epoch = esr_q[1];
  assign chip_en      = chip_en_q;
  assign code_clear   = code_clear_q;
  assign slew_ready   = (state_q == SLEW_IDLE);

endmodule

// File: tb/tb_l1ca_code_nco.sv
// Bench for l1ca_code_nco: behavioural C/A generator plus an event-count reference model.
module tb_l1ca_code_nco;

  logic               clk = 1'b0;
  logic               nrst, en, clear, fcw_valid, slew_valid;
  logic [31:0]        fcw;
  logic signed [10:0] slew_amt;
  logic               code_in, epoch_in;
  logic               slew_ready, chip_en, code_clear, early, prompt, late, prompt_epoch;

  always #5 clk = ~clk;

  l1ca_code_nco #(.NCO_W(32)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .en           (en),
    .clear        (clear),
    .fcw          (fcw),
    .fcw_valid    (fcw_valid),
    .slew_valid   (slew_valid),
    .slew_ready   (slew_ready),
    .slew_amt     (slew_amt),
    .code_in      (code_in),
    .epoch_in     (epoch_in),
    .chip_en      (chip_en),
    .code_clear   (code_clear),
    .early        (early),
    .prompt       (prompt),
    .late         (late),
    .prompt_epoch (prompt_epoch)
  );

  // PRN1 chip table and a registered generator reacting to chip_en / code_clear
  bit ca [1023];
  int gidx = 0;

  always @(posedge clk) begin
    if (nrst !== 1'b1 || code_clear === 1'b1) gidx <= 0;
    else if (chip_en === 1'b1)                gidx <= (gidx == 1022) ? 0 : gidx + 1;
  end

  assign code_in  = ca[gidx];
  assign epoch_in = (gidx == 0);

  // Reference model: counts events since resync; sample k holds chip (k+1)/2
  longint unsigned m_acc, m_fcw;
  int  m_mode, m_rem, m_nevt, m_nshift, cyc;
  int  evq[$];
  bit  x_chip_en, x_cclr;
  int  n_chk = 0, n_pass = 0, n_fail = 0;

  function automatic bit code_of(int k);
    return ca[((k + 1) / 2) % 1023];
  endfunction

  function automatic bit epoch_of(int k);
    return (((k + 1) / 2) % 1023) == 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_step();
    bit nat, evt;
    int old, amt;
    cyc++;
    if (!nrst) begin
      m_acc = 0; m_fcw = 0; m_mode = 0; m_rem = 0; m_nevt = 0; m_nshift = 0;
      evq.delete(); x_chip_en = 0; x_cclr = 0;
    end else if (clear) begin
      m_acc = 0; m_mode = 0; m_rem = 0; m_nevt = 0; m_nshift = 0;
      evq.delete(); x_chip_en = 0; x_cclr = 1;
    end else begin
      old = m_mode;
      nat = en && ((m_acc + m_fcw) >= 64'h1_0000_0000);
      if (en) m_acc = (m_acc + m_fcw) & 64'hFFFF_FFFF;
      evt = nat;
      amt = int'(slew_amt);
      if (old == 1 && en && !nat) begin
        evt = 1; m_rem--; if (m_rem == 0) m_mode = 0;
      end else if (old == 2 && nat) begin
        evt = 0; m_rem--; if (m_rem == 0) m_mode = 0;
      end else if (old == 0 && slew_valid && amt != 0) begin
        m_mode = (amt > 0) ? 1 : 2;
        m_rem  = (amt > 0) ? amt : -amt;
      end
      while (evq.size() > 0 && evq[0] == cyc - 2) begin
        void'(evq.pop_front());
        m_nshift++;
      end
      x_chip_en = evt && (m_nevt % 2 == 1);
      if (evt) begin
        m_nevt++;
        evq.push_back(cyc);
      end
      x_cclr = 0;
      if (fcw_valid) m_fcw = fcw;
    end
  endtask

  task automatic cycle();
    bit e, p, l, pe;
    @(posedge clk);
    model_step();
    @(negedge clk);
    e  = (m_nshift >= 1) ? code_of(m_nshift - 1)  : 1'b0;
    p  = (m_nshift >= 2) ? code_of(m_nshift - 2)  : 1'b0;
    l  = (m_nshift >= 3) ? code_of(m_nshift - 3)  : 1'b0;
    pe = (m_nshift >= 2) ? epoch_of(m_nshift - 2) : 1'b0;
    check("ctl{chip_en,code_clear,slew_ready}", {29'd0, chip_en, code_clear, slew_ready},
          {29'd0, x_chip_en, x_cclr, (m_mode == 0)});
    check("epl{early,prompt,late,epoch}", {28'd0, early, prompt, late, prompt_epoch},
          {28'd0, e, p, l, pe});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_slew(input int amt);
    slew_amt = 11'(amt); slew_valid = 1'b1;
    cycle();
    slew_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; cycle(); clear = 1'b0;
  endtask

  task automatic load_fcw(input logic [31:0] w);
    fcw = w; fcw_valid = 1'b1; cycle(); fcw_valid = 1'b0;
  endtask

  initial begin
    bit [10:1] g1, g2;
    bit fb1, fb2;
    int a;
    g1 = '1; g2 = '1;
    for (int i = 0; i < 1023; i++) begin
      ca[i] = g1[10] ^ g2[2] ^ g2[6];
      fb1 = g1[3] ^ g1[10];
      fb2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
      g1 = {g1[9:1], fb1};
      g2 = {g2[9:1], fb2};
    end

    nrst = 1'b0; en = 1'b0; clear = 1'b0; fcw = '0; fcw_valid = 1'b0;
    slew_valid = 1'b0; slew_amt = '0; cyc = 0;
    run(4);

    // nominal rate: one half-chip event every 8 clk
    nrst = 1'b1;
    load_fcw(32'h2000_0000);
    pulse_clear();
    en = 1'b1;
    run(300);

    // advance, retard, then a clear while a long advance is in flight
    pulse_slew(4);    run(80);
    pulse_slew(-3);   run(100);
    pulse_slew(100);  run(9);
    pulse_clear();    run(60);

    // rate change and en gating
    load_fcw(32'h4000_0000); run(60);
    en = 1'b0; run(50);
    en = 1'b1; run(40);

    // full code period at 16 clk/chip
    load_fcw(32'h2000_0000);
    pulse_clear();
    run(16500);

    // extreme slews at the fastest legal rate
    load_fcw(32'h8000_0000);
    pulse_slew(-1024); run(2100);
    pulse_slew(1023);  run(1100);

    // randomized traffic, including one mid-run reset
    for (int i = 0; i < 3000; i++) begin
      en         = ($urandom_range(0, 9) != 0);
      fcw_valid  = ($urandom_range(0, 99) == 0) || (i == 1502);
      fcw        = $urandom_range(32'h8000_0000, 32'h0800_0000);
      slew_valid = ($urandom_range(0, 19) == 0);
      a          = int'($urandom_range(0, 80)) - 40;
      slew_amt   = 11'(a);
      clear      = ($urandom_range(0, 299) == 0);
      nrst       = !(i == 1500 || i == 1501);
      cycle();
    end
    fcw_valid = 1'b0; slew_valid = 1'b0; clear = 1'b0; nrst = 1'b1;
    run(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
